// File: rtl/fir_tdm_pkg.sv
// Shared FSM encoding plus width and rounding helpers for the fir_tdm filter.
package fir_tdm_pkg;

   typedef enum logic [1:0] {ST_IDLE, ST_MAC, ST_DRAIN, ST_OUT} state_t;

   function automatic int fir_acc_width(input int data_w, input int coeff_w, input int n_taps);
      return data_w + coeff_w + $clog2(n_taps);
   endfunction

   function automatic int fir_ch_width(input int n_ch);
      return (n_ch > 1) ? $clog2(n_ch) : 1;
   endfunction

   // Half an output LSB, added before the shift so the result rounds half up.
   function automatic longint fir_round_const(input int shift);
      return (shift > 0) ? (longint'(1) <<< (shift - 1)) : longint'(0);
   endfunction

endpackage

// File: rtl/fir_mac_unit.sv
// Registered signed multiplier feeding an accumulator; clr zeroes both stages,
// en advances the pipeline (product of this cycle lands in acc one cycle later).
module fir_mac_unit
   import fir_tdm_pkg::*;
#(
   parameter int A_WIDTH   = 16,
   parameter int B_WIDTH   = 16,
   parameter int ACC_WIDTH = 36
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clr,
   input  logic                 en,
   input  logic [A_WIDTH-1:0]   a,
   input  logic [B_WIDTH-1:0]   b,
   output logic [ACC_WIDTH-1:0] acc
);

   logic signed [A_WIDTH+B_WIDTH-1:0] prod;
   logic signed [ACC_WIDTH-1:0]       acc_r;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prod  <= '0;
         acc_r <= '0;
      end else if (clr) begin
         prod  <= '0;
         acc_r <= '0;
      end else if (en) begin
         prod  <= $signed(a) * $signed(b);
         acc_r <= acc_r + {{(ACC_WIDTH-A_WIDTH-B_WIDTH){prod[A_WIDTH+B_WIDTH-1]}}, prod};
      end
   end

   assign acc = acc_r;

endmodule

// File: rtl/fir_tdm.sv
// Time-multiplexed multi-channel FIR: one shared MAC, per-channel circular delay lines,
// output valid N_TAPS+2 edges counting the accepting edge; define FIR_TDM_SAT_EN to clamp output.
module fir_tdm
   import fir_tdm_pkg::*;
#(
   parameter int DATA_WIDTH  = 16,
   parameter int COEFF_WIDTH = 16,
   parameter int N_TAPS      = 16,
   parameter int N_CH        = 4,
   parameter int OUT_SHIFT   = 15
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [fir_ch_width(N_CH)-1:0]  in_ch,
   input  logic [DATA_WIDTH-1:0]          in_data,
   input  logic                           coef_we,
   input  logic [$clog2(N_TAPS)-1:0]      coef_addr,
   input  logic [COEFF_WIDTH-1:0]         coef_data,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [fir_ch_width(N_CH)-1:0]  out_ch,
   output logic [DATA_WIDTH-1:0]          out_data
);

   localparam int CHW       = fir_ch_width(N_CH);
   localparam int AW        = $clog2(N_TAPS);
   localparam int ACC_WIDTH = fir_acc_width(DATA_WIDTH, COEFF_WIDTH, N_TAPS);
   localparam logic signed [ACC_WIDTH-1:0] RND = ACC_WIDTH'(fir_round_const(OUT_SHIFT));

   state_t                 state_q, state_d;
   logic [AW-1:0]          tap_q, newest_q, rd_idx;
   logic [CHW-1:0]         ch_q;
   logic [DATA_WIDTH-1:0]  dline [N_CH][N_TAPS];
   logic [AW-1:0]          wptr  [N_CH];
   logic [COEFF_WIDTH-1:0] coef  [N_TAPS];
   logic                   ch_ok, start, mac_en;
   logic [ACC_WIDTH-1:0]   acc;
   logic signed [ACC_WIDTH-1:0] rnd_sum, shifted;

   generate
      if (N_CH == (1 << CHW)) begin : g_ch_full
         assign ch_ok = 1'b1;
      end else begin : g_ch_part
         assign ch_ok = (in_ch < CHW'(N_CH));
      end
   endgenerate

   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      start     = 1'b0;
      mac_en    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            in_ready = 1'b1;
            // Samples for nonexistent channels are consumed without starting a computation.
            if (in_valid && ch_ok) begin
               start   = 1'b1;
               state_d = ST_MAC;
            end
         end
         ST_MAC: begin
            mac_en = 1'b1;
            if (tap_q == AW'(N_TAPS - 1)) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            mac_en  = 1'b1;
            state_d = ST_OUT;
         end
         ST_OUT: begin
            out_valid = 1'b1;
            if (out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         tap_q    <= '0;
         newest_q <= '0;
         ch_q     <= '0;
      end else begin
         state_q <= state_d;
         if (start) begin
            tap_q    <= '0;
            newest_q <= wptr[in_ch];
            ch_q     <= in_ch;
         end else if (state_q == ST_MAC) begin
            tap_q <= (tap_q == AW'(N_TAPS - 1)) ? '0 : tap_q + AW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < N_CH; c++) begin
            wptr[c] <= '0;
            for (int t = 0; t < N_TAPS; t++) dline[c][t] <= '0;
         end
         for (int t = 0; t < N_TAPS; t++) coef[t] <= '0;
      end else begin
         if (start) begin
            dline[in_ch][wptr[in_ch]] <= in_data;
            wptr[in_ch] <= (wptr[in_ch] == AW'(N_TAPS - 1)) ? '0 : wptr[in_ch] + AW'(1);
         end
         if (state_q == ST_IDLE && coef_we) coef[coef_addr] <= coef_data;
      end
   end

   // Tap k reads the sample k positions older than the newest one, wrapping the ring.
   assign rd_idx = (newest_q >= tap_q) ? (newest_q - tap_q)
                                       : (AW'(N_TAPS) + newest_q - tap_q);

   fir_mac_unit #(
      .A_WIDTH  (DATA_WIDTH),
      .B_WIDTH  (COEFF_WIDTH),
      .ACC_WIDTH(ACC_WIDTH)
   ) u_mac (
      .clk  (clk),
      .rst_n(rst_n),
      .clr  (start),
      .en   (mac_en),
      .a    (dline[ch_q][rd_idx]),
      .b    (coef[tap_q]),
      .acc  (acc)
   );

   assign rnd_sum = $signed(acc) + RND;
   assign shifted = rnd_sum >>> OUT_SHIFT;
   assign out_ch  = ch_q;

`ifdef FIR_TDM_SAT_EN
   localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
      {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
   localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

   always_comb begin
      out_data = DATA_WIDTH'(shifted);
      if (shifted > SAT_MAX)      out_data = DATA_WIDTH'(SAT_MAX);
      else if (shifted < SAT_MIN) out_data = DATA_WIDTH'(SAT_MIN);
   end
`else
   assign out_data = DATA_WIDTH'(shifted);
`endif

endmodule

// File: tb/tb_fir_tdm.sv
// Bench for fir_tdm: two instances (OUT_SHIFT 0 and 15) share stimulus and are checked
// against a sum-of-products model of the filter.
`timescale 1ns/1ps
module tb_fir_tdm;

   localparam int NT  = 16;
   localparam int NCH = 4;

   typedef struct {
      int grp;
      int ch;
      int data;
      int exp;
      bit sel15;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, out_ready, coef_we;
   logic [1:0]  in_ch;
   logic [15:0] in_data, coef_data;
   logic [3:0]  coef_addr;
   logic        in_ready0, out_valid0, in_ready15, out_valid15;
   logic [1:0]  out_ch0, out_ch15;
   logic [15:0] out_data0, out_data15;

   always #5 clk = ~clk;

   fir_tdm #(.OUT_SHIFT(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
      .in_ch(in_ch), .in_data(in_data), .coef_we(coef_we), .coef_addr(coef_addr),
      .coef_data(coef_data), .out_valid(out_valid0), .out_ready(out_ready),
      .out_ch(out_ch0), .out_data(out_data0)
   );

   fir_tdm #(.OUT_SHIFT(15)) u_dut15 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready15),
      .in_ch(in_ch), .in_data(in_data), .coef_we(coef_we), .coef_addr(coef_addr),
      .coef_data(coef_data), .out_valid(out_valid15), .out_ready(out_ready),
      .out_ch(out_ch15), .out_data(out_data15)
   );

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   accept_cyc = 0;
   int   m_coef [NT];
   int   m_hist [NCH][NT];
   vec_t vecs[$];

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
      $fatal(1, "watchdog");
   end

   function automatic longint m_acc(input int ch);
      longint s = 0;
      for (int k = 0; k < NT; k++) s += longint'(m_coef[k]) * longint'(m_hist[ch][k]);
      return s;
   endfunction

   function automatic int m_out(input longint acc, input int sh);
      longint r;
      logic signed [15:0] w;
      r = (sh > 0) ? ((acc + (longint'(1) << (sh - 1))) >>> sh) : acc;
`ifdef FIR_TDM_SAT_EN
      if (r > 32767) r = 32767;
      else if (r < -32768) r = -32768;
`endif
      w = r[15:0];
      return int'(w);
   endfunction

   function automatic int rand16();
      logic signed [15:0] v;
      v = 16'($urandom);
      return int'(v);
   endfunction

   function automatic void add_vec(input int g, input int ch, input int d, input int e, input bit s);
      vec_t v;
      v.grp = g; v.ch = ch; v.data = d; v.exp = e; v.sel15 = s;
      vecs.push_back(v);
   endfunction

   task automatic check(input string name, input longint got, input longint exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_in_ready0"}, in_ready0, 1);
      check({tag, "_in_ready15"}, in_ready15, 1);
      check({tag, "_out_valid0"}, out_valid0, 0);
      check({tag, "_out_valid15"}, out_valid15, 0);
      check({tag, "_out_data0"}, out_data0, 0);
      check({tag, "_out_data15"}, out_data15, 0);
      check({tag, "_out_ch0"}, out_ch0, 0);
      check({tag, "_out_ch15"}, out_ch15, 0);
   endtask

   task automatic model_clear();
      for (int k = 0; k < NT; k++) begin
         m_coef[k] = 0;
         for (int c = 0; c < NCH; c++) m_hist[c][k] = 0;
      end
   endtask

   task automatic do_reset(input bit chk);
      in_valid = 0; coef_we = 0; out_ready = 1; rst_n = 0;
      in_ch = 0; in_data = 0; coef_addr = 0; coef_data = 0;
      @(posedge clk); #1;
      if (chk) check_reset_state("reset");
      @(posedge clk); #1;
      rst_n = 1;
      model_clear();
   endtask

   task automatic write_coef(input int addr, input int val);
      coef_we = 1; coef_addr = 4'(addr); coef_data = 16'(val);
      @(posedge clk); #1;
      coef_we = 0;
      m_coef[addr] = val;
   endtask

   task automatic send(input int ch, input int data, input bit we, input int addr, input int cdat,
                       output int y0, output int y15);
      int n;
      longint acc;
      in_valid = 1; in_ch = 2'(ch); in_data = 16'(data);
      coef_we = we; coef_addr = 4'(addr); coef_data = 16'(cdat);
      n = 0;
      while (!in_ready0 && n < 100) begin @(posedge clk); #1; n++; end
      check("accept_ready", in_ready0, 1);
      @(posedge clk);
      accept_cyc = cyc;
      #1;
      in_valid = 0; coef_we = 0;
      if (we) m_coef[addr] = cdat;
      for (int k = NT - 1; k > 0; k--) m_hist[ch][k] = m_hist[ch][k-1];
      m_hist[ch][0] = data;
      acc = m_acc(ch);
      n = 0;
      while (!out_valid0 && n < 100) begin @(posedge clk); #1; n++; end
      check("latency", n, NT + 1);
      check("valid15", out_valid15, 1);
      check("out_ch0", out_ch0, ch);
      check("out_ch15", out_ch15, ch);
      y0  = int'($signed(out_data0));
      y15 = int'($signed(out_data15));
      check("data0", y0, m_out(acc, 0));
      check("data15", y15, m_out(acc, 15));
      if (out_ready) begin
         @(posedge clk); #1;
         check("hs_in_ready", in_ready0, 1);
         check("hs_out_valid", out_valid0, 0);
      end
   endtask

   task automatic load_group(input int g);
      for (int k = 0; k < NT; k++) begin
         if (g == 0) write_coef(k, k + 1);
         else if (g == 1) write_coef(k, 1);
      end
      if (g == 2) write_coef(0, 16384);
   endtask

   initial begin
      int y0, y15, cur, prev, n, d0;
      bit we;
      rst_n = 0; in_valid = 0; coef_we = 0; out_ready = 1;
      in_ch = 0; in_data = 0; coef_addr = 0; coef_data = 0;

      for (int i = 0; i <= NT; i++) add_vec(0, 0, (i == 0) ? 100 : 0, (i < NT) ? 100 * (i + 1) : 0, 0);
      for (int i = 0; i <= NT; i++) begin
         add_vec(1, 0, 10, (i < NT) ? 10 * (i + 1) : 160, 0);
         add_vec(1, 1, (i == 0) ? 50 : 0, (i < NT) ? 50 : 0, 0);
      end
      add_vec(2, 0, 3, 2, 1);
      add_vec(2, 0, -3, -1, 1);
      add_vec(2, 0, 1, 1, 1);

      do_reset(1);

      cur = -1; prev = -1;
      for (int i = 0; i < vecs.size(); i++) begin
         if (vecs[i].grp != cur) begin
            cur = vecs[i].grp;
            do_reset(0);
            load_group(cur);
            prev = -1;
         end
         send(vecs[i].ch, vecs[i].data, 0, 0, 0, y0, y15);
         check($sformatf("vec%0d", i), vecs[i].sel15 ? y15 : y0, vecs[i].exp);
         if (prev >= 0) check($sformatf("throughput%0d", i), accept_cyc - prev, NT + 3);
         prev = accept_cyc;
      end

      do_reset(0);
      for (int k = 0; k < NT; k++) write_coef(k, 32767);
      for (int i = 0; i < NT; i++) send(2, 32767, 0, 0, 0, y0, y15);
`ifdef FIR_TDM_SAT_EN
      check("sat0", y0, 32767);
      check("sat15", y15, 32767);
`else
      check("wrap0", y0, 16);
      check("wrap15", y15, -32);
`endif

      do_reset(0);
      for (int k = 0; k < NT; k++) write_coef(k, 3 * k - 20);
      out_ready = 0;
      send(1, 1234, 0, 0, 0, y0, y15);
      d0 = y0;
      for (int i = 0; i < 10; i++) begin
         if (i == 3) begin coef_we = 1; coef_addr = 0; coef_data = 16'(5000); end
         if (i == 4) coef_we = 0;
         if (i == 5) begin in_valid = 1; in_ch = 0; in_data = 16'(999); end
         if (i == 8) in_valid = 0;
         @(posedge clk); #1;
         check("bp_data", $signed(out_data0), d0);
         check("bp_ch", out_ch0, 1);
         check("bp_in_ready", in_ready0, 0);
         check("bp_valid", out_valid0, 1);
      end
      out_ready = 1;
      @(posedge clk); #1;
      check("bp_release_valid", out_valid0, 0);
      check("bp_release_ready", in_ready0, 1);
      send(1, -777, 0, 0, 0, y0, y15);

      do_reset(0);
      for (int k = 0; k < NT; k++) write_coef(k, k + 1);
      in_valid = 1; in_ch = 0; in_data = 16'(100);
      @(posedge clk); #1;
      in_valid = 0;
      repeat (5) @(posedge clk);
      #1;
      rst_n = 0;
      #1;
      check_reset_state("midmac");
      @(posedge clk); #1;
      rst_n = 1;
      model_clear();
      n = 0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk); #1;
         if (out_valid0 || out_valid15) n++;
      end
      check("abort_no_output", n, 0);
      send(0, 100, 0, 0, 0, y0, y15);
      check("cleared_coef0", y0, 0);
      check("cleared_coef15", y15, 0);

      do_reset(0);
      for (int k = 0; k < NT; k++) write_coef(k, rand16());
      for (int i = 0; i < 40; i++) begin
         we = ($urandom_range(0, 3) == 0);
         send(int'($urandom_range(0, NCH - 1)), rand16(), we, int'($urandom_range(0, NT - 1)),
              rand16(), y0, y15);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
